input_unloader: RTL and testbench
=================================

# input_unloader

Receive-side deframer for the watchdog nibble byte stream. Consumes the byte-wide stream produced by the watchdog output loader, where each byte is {mode[2:0], rdy, nibble[3:0]}. It reassembles two W-bit words (A then B, most-significant nibble first) and presents them with the frame's mode and a one-cycle valid strobe. It sits at the watchdog link input, feeding the compare/check logic, and flags malformed frames.

## Interface
- W, 32, word width in bits; multiple of 4, ≥ 8; NIB = W/4 nibbles per word
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_byte  in  8  link byte: [7:5] mode, [4] rdy, [3:0] nibble
- busy  out  1  high while a frame is in progress (any state except IDLE)
- word_a  out  W  last good word A; holds until next good frame
- word_b  out  W  last good word B; holds until next good frame
- mode_out  out  3  mode of last good frame
- frame_valid  out  1  one-cycle pulse: word_a/word_b/mode_out just updated
- err_short  out  1  one-cycle pulse: rdy dropped before 2·NIB nibbles
- err_mode  out  1  one-cycle pulse: mode field changed mid-frame
- err_long  out  1  one-cycle pulse: rdy still high after 2·NIB nibbles

## Operation
- Frame = exactly 2·NIB consecutive cycles with in_byte[4]=1 and constant mode, followed by ≥1 cycle with in_byte[4]=0
- States: IDLE, RECV_A, RECV_B, WAIT_LOW
- IDLE: on rdy=1, capture mode into cur_mode, shift nibble into A shift register, cnt ← 1, go RECV_A
- RECV_A: rdy=1 and mode==cur_mode: shift in nibble ({sr[W-5:0], nib}); on NIB-th nibble go RECV_B, cnt ← 0
- RECV_B: same for B; on the NIB-th B nibble commit: word_a ← sr_a, word_b ← {sr_b[W-5:0], nib}, mode_out ← cur_mode, frame_valid=1, go WAIT_LOW
- WAIT_LOW: rdy=0 → IDLE; rdy=1 on the first WAIT_LOW cycle → err_long pulse once, stay until rdy=0 (bytes ignored, committed frame kept)
- rdy=0 in RECV_A/RECV_B → err_short, discard partial data, IDLE
- rdy=1 with mode≠cur_mode in RECV_A/RECV_B → err_mode, discard, WAIT_LOW (no err_long for that frame)
- Discarded frames never touch word_a/word_b/mode_out
- Nibble bits are never interpreted when rdy=0
- Counter width $clog2(NIB)+1; no arithmetic beyond increment/compare

## Timing
- Reset: state IDLE, busy=0, word_a=word_b=0, mode_out=0, all pulses 0, shift regs and counter 0, stats counters 0
- in_byte sampled directly on clk edge, no input register
- Latency: edge sampling last B nibble → word_a/word_b/mode_out/frame_valid valid immediately after that edge (1 cycle)
- busy rises after the edge sampling the first rdy=1 byte; falls after the edge sampling rdy=0 in WAIT_LOW or an err_short
- Error pulses and frame_valid are registered, exactly one cycle wide, mutually exclusive per cycle
- Min frame spacing: 2·NIB+1 cycles; new frame may start on the cycle right after the rdy=0 byte
- Reset mid-frame: immediate return to reset values, partial frame lost, no pulses

## Configuration
- WATCHDOG_RX_STATS_EN defined: adds outputs frame_cnt[15:0] (increments with frame_valid) and err_cnt[15:0] (increments on any error pulse); both saturate at 16'hFFFF, reset to 0
- Undefined: ports and counters absent; all other behaviour identical

## Structure
- watchdog_pkg: rx_state_t enum (IDLE, RECV_A, RECV_B, WAIT_LOW), byte field constants (MODE_MSB=7, MODE_LSB=5, RDY_BIT=4, NIB_MSB=3)
- One sub-module: nibble_shift_reg (W-bit MSB-first nibble shifter with load/clear), instanced for A and B

## Test plan
- W=32, frame A=32'h1234_5678, B=32'h9ABC_DEF0, mode 3'b101 → one frame_valid, word_a/word_b/mode_out match, busy low after trailing rdy=0
- Two frames back-to-back with one rdy=0 gap → two frame_valid pulses, second values overwrite first
- rdy drops after 11 nibbles → err_short one cycle, outputs retain previous frame, IDLE
- Mode changes 101→011 at nibble 5 → err_mode, no frame_valid, recovers on next good frame
- rdy held high 3 cycles past 16 nibbles → frame_valid then err_long once, data kept
- rst_n asserted at nibble 9 → all outputs 0, next full frame received correctly; with WATCHDOG_RX_STATS_EN, frame_cnt/err_cnt match counts above

Source files
------------

// File: rtl/watchdog_pkg.sv
// watchdog_pkg: shared receive-side FSM states and link byte field positions
package watchdog_pkg;
    typedef enum logic [1:0] {IDLE, RECV_A, RECV_B, WAIT_LOW} rx_state_t;
    localparam int MODE_MSB = 7;
    localparam int MODE_LSB = 5;
    localparam int RDY_BIT  = 4;
    localparam int NIB_MSB  = 3;
endpackage

// File: rtl/nibble_shift_reg.sv
// nibble_shift_reg: W-bit MSB-first nibble shifter with synchronous clear
module nibble_shift_reg
    import watchdog_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           shift,
    input  logic [NIB_MSB:0] nib,
    output logic [W-1:0]   q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (clr) q <= '0;
        else if (shift) q <= {q[W-5:0], nib};
endmodule

// File: rtl/input_unloader.sv
// input_unloader: watchdog nibble-stream deframer; WATCHDOG_RX_STATS_EN adds frame_cnt/err_cnt outputs
module input_unloader
    import watchdog_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_byte,
    output logic         busy,
    output logic [W-1:0] word_a,
    output logic [W-1:0] word_b,
    output logic [2:0]   mode_out,
    output logic         frame_valid,
    output logic         err_short,
    output logic         err_mode,
    output logic         err_long
`ifdef WATCHDOG_RX_STATS_EN
    ,
    output logic [15:0]  frame_cnt,
    output logic [15:0]  err_cnt
`endif
);
    localparam int NIB = W / 4;
    localparam int CW  = $clog2(NIB) + 1;

    rx_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] cur_mode, cur_mode_n;
    logic first, first_n;
    logic sh_a, sh_b, clr, commit, e_short, e_mode, e_long;
    logic [W-1:0] sr_a, sr_b;
    logic b_top_unused;

    wire rdy = in_byte[RDY_BIT];
    wire [2:0] mode = in_byte[MODE_MSB:MODE_LSB];
    wire [NIB_MSB:0] nib = in_byte[NIB_MSB:0];
    wire last = cnt == CW'(NIB - 1);

    // the oldest B nibble is never needed: the committed word_b is taken from the shifted view
    assign b_top_unused = ^sr_b[W-1:W-4];
    assign busy = state != IDLE;

    nibble_shift_reg #(.W(W)) u_sr_a (.clk(clk), .rst_n(rst_n), .clr(clr), .shift(sh_a), .nib(nib), .q(sr_a));
    nibble_shift_reg #(.W(W)) u_sr_b (.clk(clk), .rst_n(rst_n), .clr(clr), .shift(sh_b), .nib(nib), .q(sr_b));

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        cur_mode_n = cur_mode;
        first_n = 1'b0;
        sh_a = 1'b0;
        sh_b = 1'b0;
        clr = 1'b0;
        commit = 1'b0;
        e_short = 1'b0;
        e_mode = 1'b0;
        e_long = 1'b0;
        case (state)
            IDLE: if (rdy) begin
                state_n = RECV_A;
                cnt_n = CW'(1);
                cur_mode_n = mode;
                sh_a = 1'b1;
            end
            RECV_A, RECV_B: if (!rdy || mode != cur_mode) begin
                e_short = !rdy;
                e_mode = rdy;
                clr = 1'b1;
                cnt_n = '0;
                state_n = rdy ? WAIT_LOW : IDLE;
            end else begin
                sh_a = state == RECV_A;
                sh_b = state == RECV_B;
                cnt_n = last ? '0 : cnt + 1'b1;
                commit = last && state == RECV_B;
                clr = commit;
                first_n = commit;
                state_n = !last ? state : state == RECV_A ? RECV_B : WAIT_LOW;
            end
            WAIT_LOW: begin
                e_long = first && rdy;
                state_n = rdy ? WAIT_LOW : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            cur_mode <= '0;
            first <= 1'b0;
            word_a <= '0;
            word_b <= '0;
            mode_out <= '0;
            frame_valid <= 1'b0;
            err_short <= 1'b0;
            err_mode <= 1'b0;
            err_long <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            cur_mode <= cur_mode_n;
            first <= first_n;
            frame_valid <= commit;
            err_short <= e_short;
            err_mode <= e_mode;
            err_long <= e_long;
            if (commit) begin
                word_a <= sr_a;
                word_b <= {sr_b[W-5:0], nib};
                mode_out <= cur_mode;
            end
        end

`ifdef WATCHDOG_RX_STATS_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (commit && ~&frame_cnt) frame_cnt <= frame_cnt + 1'b1;
            if ((e_short || e_mode || e_long) && ~&err_cnt) err_cnt <= err_cnt + 1'b1;
        end
`endif
endmodule

// File: tb/tb_input_unloader.sv
// tb_input_unloader: directed scoreboard bench for input_unloader (W=32)
module tb_input_unloader;
    localparam int EV_FRAME = 1, EV_SHORT = 2, EV_MODE = 3, EV_LONG = 4;
    localparam logic [7:0] GAP = 8'hEF;

    typedef struct {
        int kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0] m;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic busy, frame_valid, err_short, err_mode, err_long;
    logic [31:0] word_a, word_b;
    logic [2:0] mode_out;
`ifdef WATCHDOG_RX_STATS_EN
    logic [15:0] frame_cnt, err_cnt;
`endif

    int n_assert = 0;
    int n_fail = 0;
    ev_t sb[$];

    input_unloader #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .busy(busy),
        .word_a(word_a), .word_b(word_b), .mode_out(mode_out),
        .frame_valid(frame_valid), .err_short(err_short), .err_mode(err_mode), .err_long(err_long)
`ifdef WATCHDOG_RX_STATS_EN
        , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.m = m;
        sb.push_back(e);
    endtask

    task automatic monitor();
        int k;
        ev_t e;
        k = frame_valid ? EV_FRAME : err_short ? EV_SHORT : err_mode ? EV_MODE : err_long ? EV_LONG : 0;
        chk("pulse_onehot", 64'($countones({frame_valid, err_short, err_mode, err_long}) <= 1), 64'(1));
        if (k != 0) begin
            if (sb.size() == 0) chk("unexpected_pulse", 64'(k), 64'(0));
            else begin
                e = sb.pop_front();
                chk("event_kind", 64'(k), 64'(e.kind));
                if (k == EV_FRAME) begin
                    chk("sb_word_a", 64'(word_a), 64'(e.a));
                    chk("sb_word_b", 64'(word_b), 64'(e.b));
                    chk("sb_mode_out", 64'(mode_out), 64'(e.m));
                end
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_byte = b;
        @(posedge clk);
        #1;
        monitor();
    endtask

    function automatic logic [7:0] nb(input logic [2:0] m, input logic [31:0] w, input int i);
        return {m, 1'b1, w[31-4*i -: 4]};
    endfunction

    task automatic frame(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) push(EV_FRAME, a, b, m);
            send(nb(m, i < 8 ? a : b, i % 8));
            chk("busy_in_frame", 64'(busy), 64'(1));
        end
    endtask

    task automatic chk_words(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
        chk({tag, "_word_a"}, 64'(word_a), 64'(a));
        chk({tag, "_word_b"}, 64'(word_b), 64'(b));
        chk({tag, "_mode_out"}, 64'(mode_out), 64'(m));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk_words("rst", 32'h0, 32'h0, 3'b000);
        chk("rst_pulses", 64'({frame_valid, err_short, err_mode, err_long}), 64'(0));
        @(negedge clk) rst_n = 1'b1;

        // single frame
        frame(32'h1234_5678, 32'h9ABC_DEF0, 3'b101);
        send(GAP);
        chk("t1_busy_low", 64'(busy), 64'(0));
        chk_words("t1", 32'h1234_5678, 32'h9ABC_DEF0, 3'b101);

        // back-to-back frames with one gap cycle
        frame(32'hA5A5_0001, 32'h5A5A_0002, 3'b010);
        send(GAP);
        frame(32'hFEDC_BA98, 32'h7654_3210, 3'b111);
        send(GAP);
        chk_words("t2", 32'hFEDC_BA98, 32'h7654_3210, 3'b111);

        // rdy drops after 11 nibbles
        for (int i = 0; i < 11; i++) send(nb(3'b101, i < 8 ? 32'hC0FF_EE00 : 32'hDEAD_BEEF, i % 8));
        push(EV_SHORT, 0, 0, 0);
        send(GAP);
        chk("t3_busy_low", 64'(busy), 64'(0));
        chk_words("t3", 32'hFEDC_BA98, 32'h7654_3210, 3'b111);

        // mode changes at nibble 5, tail of frame ignored
        for (int i = 0; i < 4; i++) send(nb(3'b101, 32'h1111_2222, i));
        push(EV_MODE, 0, 0, 0);
        send(nb(3'b011, 32'h1111_2222, 4));
        for (int i = 5; i < 16; i++) send(nb(3'b011, i < 8 ? 32'h1111_2222 : 32'h3333_4444, i % 8));
        chk("t4_busy_wait", 64'(busy), 64'(1));
        send(GAP);
        chk("t4_busy_low", 64'(busy), 64'(0));
        chk_words("t4", 32'hFEDC_BA98, 32'h7654_3210, 3'b111);
        frame(32'h0BAD_F00D, 32'h600D_CAFE, 3'b011);
        send(GAP);
        chk_words("t4_recover", 32'h0BAD_F00D, 32'h600D_CAFE, 3'b011);

        // rdy held high 3 cycles past the frame
        frame(32'h2468_ACE0, 32'h1357_9BDF, 3'b001);
        push(EV_LONG, 0, 0, 0);
        repeat (3) send(8'h3A);
        chk("t5_busy_hold", 64'(busy), 64'(1));
        send(GAP);
        chk("t5_busy_low", 64'(busy), 64'(0));
        chk_words("t5", 32'h2468_ACE0, 32'h1357_9BDF, 3'b001);
`ifdef WATCHDOG_RX_STATS_EN
        chk("stats_frames", 64'(frame_cnt), 64'(5));
        chk("stats_errs", 64'(err_cnt), 64'(3));
`endif

        // asynchronous reset at nibble 9
        for (int i = 0; i < 9; i++) send(nb(3'b110, i < 8 ? 32'h8765_4321 : 32'h0F0F_0F0F, i % 8));
        rst_n = 1'b0;
        in_byte = 8'h00;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'(0));
        chk_words("t6_rst", 32'h0, 32'h0, 3'b000);
        chk("t6_rst_pulses", 64'({frame_valid, err_short, err_mode, err_long}), 64'(0));
`ifdef WATCHDOG_RX_STATS_EN
        chk("t6_rst_frames", 64'(frame_cnt), 64'(0));
        chk("t6_rst_errs", 64'(err_cnt), 64'(0));
`endif
        @(negedge clk) rst_n = 1'b1;
        send(GAP);
        frame(32'h8765_4321, 32'h0F0F_0F0F, 3'b110);
        send(GAP);
        chk("t6_busy_low", 64'(busy), 64'(0));
        chk_words("t6", 32'h8765_4321, 32'h0F0F_0F0F, 3'b110);
`ifdef WATCHDOG_RX_STATS_EN
        chk("t6_frames", 64'(frame_cnt), 64'(1));
        chk("t6_errs", 64'(err_cnt), 64'(0));
`endif

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
